// File: rtl/battery_if.sv
// Battery controller handshake bundle: charger/load controls in, level and status out.
interface battery_if #(
  parameter int LEVEL_W = 5
);
  logic               charge_en;
  logic               load_en;
  logic [LEVEL_W-1:0] load_val;
  logic [LEVEL_W-1:0] level;
  logic [1:0]         mode;
  logic               full;
  logic               empty;
  logic               low_pulse;

  modport master (
    output charge_en, load_en, load_val,
    input  level, mode, full, empty, low_pulse
  );

  modport slave (
    input  charge_en, load_en, load_val,
    output level, mode, full, empty, low_pulse
  );
endinterface

// File: rtl/battery_controller.sv
// Battery level register with periodic drain/charge stepping and DISCHG/CHG/FULL/EMPTY sequencing.
// A direct load overrides stepping and picks the mode that matches the loaded value.
module battery_controller #(
  parameter int LEVEL_W       = 5,
  parameter int MAX_LEVEL     = 30,
  parameter int DRAIN_PERIOD  = 1000,
  parameter int CHARGE_PERIOD = 250,
  parameter int LOW_LEVEL     = 5
) (
  input  logic     clk,
  input  logic     rst,
  battery_if.slave bus
);
  typedef enum logic [1:0] {DISCHG = 2'b00, CHG = 2'b01, FULL = 2'b10, EMPTY = 2'b11} mode_e;

  localparam int MAXP = (DRAIN_PERIOD > CHARGE_PERIOD) ? DRAIN_PERIOD : CHARGE_PERIOD;
  localparam int PW   = $clog2(MAXP);
  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LLOW = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] ONE  = LEVEL_W'(1);
  localparam logic [PW-1:0]      DWRAP = PW'(DRAIN_PERIOD - 1);
  localparam logic [PW-1:0]      CWRAP = PW'(CHARGE_PERIOD - 1);
  localparam logic [PW-1:0]      PONE  = PW'(1);

  mode_e              mode_q;
  logic [LEVEL_W-1:0] level_q;
  logic [PW-1:0]      presc;
  logic               low_q;
  logic [LEVEL_W-1:0] load_clamp;

  always_comb begin
    load_clamp = bus.load_val;
    if (bus.load_val > LMAX) load_clamp = LMAX;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LMAX;
      mode_q  <= DISCHG;
      presc   <= '0;
      low_q   <= 1'b0;
    end else begin
      low_q <= 1'b0;
      if (bus.load_en) begin
        level_q <= load_clamp;
        presc   <= '0;
        if (bus.charge_en) mode_q <= (load_clamp == LMAX) ? FULL : CHG;
        else               mode_q <= (load_clamp == '0) ? EMPTY : DISCHG;
      end else begin
        // A charger edge switches mode and drops any tick landing on the same edge.
        unique case (mode_q)
          DISCHG: begin
            if (bus.charge_en) begin
              mode_q <= CHG;
              presc  <= '0;
            end else if (presc == DWRAP) begin
              presc <= '0;
              if (level_q != '0) level_q <= level_q - ONE;
              if (level_q <= ONE) mode_q <= EMPTY;
              low_q <= (level_q == LLOW);
            end else begin
              presc <= presc + PONE;
            end
          end
          CHG: begin
            if (!bus.charge_en) begin
              mode_q <= DISCHG;
              presc  <= '0;
            end else if (presc == CWRAP) begin
              presc <= '0;
              if (level_q >= LMAX - ONE) begin
                level_q <= LMAX;
                mode_q  <= FULL;
              end else begin
                level_q <= level_q + ONE;
              end
            end else begin
              presc <= presc + PONE;
            end
          end
          FULL: begin
            if (!bus.charge_en) begin
              mode_q <= DISCHG;
              presc  <= '0;
            end
          end
          EMPTY: begin
            if (bus.charge_en) begin
              mode_q <= CHG;
              presc  <= '0;
            end
          end
        endcase
      end
    end
  end

  assign bus.level     = level_q;
  assign bus.mode      = mode_q;
  assign bus.full      = (level_q == LMAX);
  assign bus.empty     = (level_q == '0);
  assign bus.low_pulse = low_q;
endmodule

// File: tb/tb_battery_controller.sv
// Directed bench for battery_controller: behavioural model checked every cycle plus literal expectations.
module tb_battery_controller;
  localparam int LW = 5, MAXL = 30, DP = 4, CP = 2, LOWL = 5;
  localparam int M_DIS = 0, M_CHG = 1, M_FULL = 2, M_EMPTY = 3;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  battery_if #(.LEVEL_W(LW)) bif ();

  battery_controller #(
    .LEVEL_W(LW), .MAX_LEVEL(MAXL), .DRAIN_PERIOD(DP), .CHARGE_PERIOD(CP), .LOW_LEVEL(LOWL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: "age" counts edges spent stepping in the current mode since entry or load.
  int m_level = MAXL;
  int m_mode  = M_DIS;
  int m_age   = 0;
  int m_low   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = MAXL; m_mode = M_DIS; m_age = 0; m_low = 0;
    end else begin
      m_low = 0;
      if (bif.load_en) begin
        int v;
        v = (int'(bif.load_val) > MAXL) ? MAXL : int'(bif.load_val);
        m_level = v;
        m_age   = 0;
        if (bif.charge_en) m_mode = (v == MAXL) ? M_FULL : M_CHG;
        else               m_mode = (v == 0) ? M_EMPTY : M_DIS;
      end else if (bif.charge_en && (m_mode == M_DIS || m_mode == M_EMPTY)) begin
        m_mode = M_CHG; m_age = 0;
      end else if (!bif.charge_en && (m_mode == M_CHG || m_mode == M_FULL)) begin
        m_mode = M_DIS; m_age = 0;
      end else if (m_mode == M_DIS) begin
        m_age++;
        if (m_age == DP) begin
          m_age = 0;
          if (m_level == LOWL) m_low = 1;
          m_level = (m_level > 0) ? m_level - 1 : 0;
          if (m_level == 0) m_mode = M_EMPTY;
        end
      end else if (m_mode == M_CHG) begin
        m_age++;
        if (m_age == CP) begin
          m_age = 0;
          m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
          if (m_level == MAXL) m_mode = M_FULL;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_level", int'(bif.level), m_level);
    chk("cmp_mode",  int'(bif.mode), m_mode);
    chk("cmp_full",  int'(bif.full), (m_level == MAXL) ? 1 : 0);
    chk("cmp_empty", int'(bif.empty), (m_level == 0) ? 1 : 0);
    chk("cmp_low",   int'(bif.low_pulse), m_low);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input int v);
    bif.load_val = LW'(v);
    bif.load_en  = 1'b1;
    cyc(1);
    bif.load_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bif.charge_en = 1'b0;
    bif.load_en   = 1'b0;
    bif.load_val  = '0;
    #7;
    chk("rst_level", int'(bif.level), 30);
    chk("rst_mode",  int'(bif.mode), 0);
    chk("rst_full",  int'(bif.full), 1);
    chk("rst_empty", int'(bif.empty), 0);
    #5 rst = 1'b0;

    // Drain to empty
    cyc(4);
    chk("drain_first", int'(bif.level), 29);
    cyc(115);
    chk("drain_119", int'(bif.level), 1);
    cyc(1);
    chk("drain_empty_lvl", int'(bif.level), 0);
    chk("drain_empty_mode", int'(bif.mode), 3);
    chk("drain_empty_flag", int'(bif.empty), 1);
    cyc(20);
    chk("empty_hold", int'(bif.level), 0);

    // Charge from empty
    bif.charge_en = 1'b1;
    cyc(1);
    chk("chg_mode", int'(bif.mode), 1);
    chk("chg_lvl0", int'(bif.level), 0);
    cyc(2);
    chk("chg_first", int'(bif.level), 1);
    cyc(57);
    chk("chg_59", int'(bif.level), 29);
    cyc(1);
    chk("full_lvl", int'(bif.level), 30);
    chk("full_mode", int'(bif.mode), 2);
    chk("full_flag", int'(bif.full), 1);
    bif.charge_en = 1'b0;
    cyc(1);
    chk("unplug_mode", int'(bif.mode), 0);
    chk("unplug_lvl", int'(bif.level), 30);

    // Low pulse
    do_load(5);
    chk("ld5_lvl", int'(bif.level), 5);
    cyc(3);
    chk("ld5_nolow", int'(bif.low_pulse), 0);
    cyc(1);
    chk("low_lvl", int'(bif.level), 4);
    chk("low_pulse", int'(bif.low_pulse), 1);
    cyc(1);
    chk("low_gone", int'(bif.low_pulse), 0);
    do_load(3);
    chk("ld3_nolow", int'(bif.low_pulse), 0);
    cyc(4);
    chk("ld3_step", int'(bif.level), 2);

    // Load clamp
    do_load(31);
    chk("clamp_lvl", int'(bif.level), 30);
    chk("clamp_full", int'(bif.full), 1);
    chk("clamp_mode", int'(bif.mode), 0);
    do_load(0);
    chk("ld0_lvl", int'(bif.level), 0);
    chk("ld0_mode", int'(bif.mode), 3);

    // Load beats a coincident drain tick
    do_load(10);
    cyc(3);
    do_load(20);
    chk("ldtick_lvl", int'(bif.level), 20);
    cyc(3);
    chk("ldtick_hold", int'(bif.level), 20);
    cyc(1);
    chk("ldtick_step", int'(bif.level), 19);

    // Async reset mid-charge
    bif.charge_en = 1'b1;
    do_load(12);
    chk("pre_rst_mode", int'(bif.mode), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_lvl", int'(bif.level), 30);
    chk("arst_mode", int'(bif.mode), 0);
    #3;
    rst = 1'b0;
    bif.charge_en = 1'b0;
    cyc(4);
    chk("post_rst_step", int'(bif.level), 29);

    // Charger arriving on a wrap edge suppresses the tick
    cyc(3);
    bif.charge_en = 1'b1;
    cyc(1);
    chk("supp_mode", int'(bif.mode), 1);
    chk("supp_lvl", int'(bif.level), 29);
    cyc(2);
    chk("supp_full", int'(bif.mode), 2);

    // Load MAX with charger present goes straight to FULL
    do_load(30);
    chk("ldmax_chg", int'(bif.mode), 2);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
